// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : MEM-stage data memory with wait states, sized/signed
//                      loads, byte-lane stores and access-error reporting.
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    func3_q, func3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          re_q, re_d;
    logic          we_q, we_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;
    logic [3:0]    st_be;
    logic          acc_err;
    logic          wr_en;

    // Address bits above the memory size are deliberately ignored (wrap).
    logic          unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign accept    = req_valid && (state_q == ST_IDLE) && (req_re || req_we);
    assign req_ready = (state_q == ST_IDLE);
    assign stall     = reset_n && (accept || (state_q == ST_WAIT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        wdata_d = wdata_q;
        re_d    = re_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr[AW+1:0];
                    func3_d = req_func3;
                    wdata_d = req_wdata;
                    re_d    = req_re;
                    we_d    = req_we;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            func3_q <= 3'd0;
            wdata_q <= 32'd0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wdata_q <= wdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
        end
    end

    assign off     = addr_q[1:0];
    assign idx     = addr_q[AW+1:2];
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{off, 3'b000} +: 8];
    assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    // Size/sign decode; store lanes get the low data replicated across them.
    always_comb begin
        acc_err = 1'b0;
        ld_data = 32'd0;
        st_word = wdata_q;
        st_be   = 4'b0000;
        if (re_q && we_q) begin
            acc_err = 1'b1;
        end else begin
            case (func3_q)
                3'b000: begin
                    ld_data = {{24{rd_byte[7]}}, rd_byte};
                    st_word = {4{wdata_q[7:0]}};
                    st_be   = 4'b0001 << off;
                end
                3'b001: begin
                    if (off[0]) begin
                        acc_err = 1'b1;
                    end else begin
                        ld_data = {{16{rd_half[15]}}, rd_half};
                        st_word = {2{wdata_q[15:0]}};
                        st_be   = off[1] ? 4'b1100 : 4'b0011;
                    end
                end
                3'b010: begin
                    if (off != 2'b00) begin
                        acc_err = 1'b1;
                    end else begin
                        ld_data = rd_word;
                        st_be   = 4'b1111;
                    end
                end
                3'b100: begin
                    if (we_q) acc_err = 1'b1;
                    else      ld_data = {24'd0, rd_byte};
                end
                3'b101: begin
                    if (we_q || off[0]) acc_err = 1'b1;
                    else                ld_data = {16'd0, rd_half};
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && acc_err;
    assign rsp_rdata = (rsp_valid && re_q && !acc_err) ? ld_data : 32'd0;
    assign wr_en     = rsp_valid && we_q && !acc_err;

    // Contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// tb_data_mem_responder : directed and randomized accesses checked against a
// byte-addressed reference memory; a second instance exercises zero wait states.
module tb_data_mem_responder;
    localparam int DEPTH = 512;
    localparam int WAITC = 2;
    localparam int MEMB  = DEPTH * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid, req_re, req_we, req_ready;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_func3;
    logic        rsp_valid, rsp_err, stall;

    logic        z_valid, z_re, z_we, z_ready, z_rvalid, z_err, z_stall;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [2:0]  z_func3;

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_m [MEMB];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_re(req_re), .req_we(req_we),
        .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .req_valid(z_valid), .req_ready(z_ready), .req_re(z_re), .req_we(z_we),
        .req_addr(z_addr), .req_func3(z_func3), .req_wdata(z_wdata),
        .rsp_valid(z_rvalid), .rsp_rdata(z_rdata), .rsp_err(z_err), .stall(z_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: legality rules, then byte-wise read/write of the model array.
    task automatic model(input logic re, input logic we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         output logic [31:0] er, output logic ee);
        int size, base;
        logic [31:0] v;
        er = 32'd0;
        if (re && we)  ee = 1'b1;
        else if (we)   ee = !(f3 inside {3'd0, 3'd1, 3'd2});
        else           ee = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (!ee && (addr % size) != 0) ee = 1'b1;
        if (ee) return;
        base = int'(addr % MEMB);
        if (we) begin
            for (int i = 0; i < size; i++) mem_m[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_m[base + i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            er = v;
        end
    endtask

    task automatic do_req(input logic re, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] g_rd, output logic g_err);
        logic [31:0] er;
        logic ee;
        int lat;
        logic got;
        model(re, we, addr, f3, wd, er, ee);
        @(posedge clk); #1;
        req_valid = 1'b1; req_re = re; req_we = we;
        req_addr = addr; req_func3 = f3; req_wdata = wd;
        #1;
        check_eq("ready_idle", req_ready, 1);
        check_eq("stall_accept", stall, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
        #1;
        lat = 1; got = 1'b0; g_rd = 32'd0; g_err = 1'b0;
        while (!got && lat <= 20) begin
            if (rsp_valid) begin
                got = 1'b1;
                check_eq("latency", lat, WAITC + 1);
                check_eq("rsp_err", rsp_err, ee);
                check_eq("rsp_rdata", rsp_rdata, er);
                check_eq("stall_resp", stall, 0);
                check_eq("ready_resp", req_ready, 0);
                g_rd = rsp_rdata; g_err = rsp_err;
            end else begin
                check_eq("stall_wait", stall, 1);
                check_eq("rdata_no_rsp", rsp_rdata, 0);
                @(posedge clk); #2;
                lat++;
            end
        end
        if (!got) check_eq("rsp_timeout", got, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        logic er;
        reset_n = 1'b0;
        req_valid = 1'b1; req_re = 1'b1; req_we = 1'b0;
        req_addr = 32'd0; req_func3 = 3'd2; req_wdata = 32'd0;
        z_valid = 1'b0; z_re = 1'b0; z_we = 1'b0;
        z_addr = 32'd0; z_func3 = 3'd0; z_wdata = 32'd0;
        #12;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        check_eq("rst_err", rsp_err, 0);
        check_eq("rst_stall", stall, 0);
        req_valid = 1'b0; req_re = 1'b0;
        #5 reset_n = 1'b1;
        #1 check_eq("ready_after_rst", req_ready, 1);

        for (int k = 0; k < 16; k++) do_req(1'b0, 1'b1, 32'(k*4), 3'd2, $urandom, rd, er);

        do_req(1'b0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, er);
        do_req(1'b1, 1'b0, 32'h10, 3'd2, 32'd0, rd, er);
        check_eq("lw_deadbeef", rd, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 32'h13, 3'd0, 32'h80, rd, er);
        do_req(1'b1, 1'b0, 32'h13, 3'd0, 32'd0, rd, er);
        check_eq("lb_signext", rd, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 32'h13, 3'd4, 32'd0, rd, er);
        check_eq("lbu_zeroext", rd, 32'h00000080);
        do_req(1'b1, 1'b0, 32'h10, 3'd2, 32'd0, rd, er);
        check_eq("lw_after_sb", rd, 32'h80ADBEEF);
        do_req(1'b1, 1'b0, 32'h11, 3'd1, 32'd0, rd, er);
        check_eq("lh_misalign_err", er, 1);
        do_req(1'b0, 1'b1, 32'h12, 3'd2, 32'h11111111, rd, er);
        check_eq("sw_misalign_err", er, 1);
        do_req(1'b1, 1'b0, 32'h10, 3'd2, 32'd0, rd, er);
        check_eq("lw_unchanged", rd, 32'h80ADBEEF);
        do_req(1'b0, 1'b1, 32'h800, 3'd2, 32'h1234, rd, er);
        do_req(1'b1, 1'b0, 32'h0, 3'd2, 32'd0, rd, er);
        check_eq("wrap", rd, 32'h00001234);

        // Request with neither read nor write must be ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; req_re = 1'b0; req_we = 1'b0; req_addr = 32'h4;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("noop_stall", stall, 0);
            check_eq("noop_ready", req_ready, 1);
            check_eq("noop_rsp", rsp_valid, 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;

        // Reset during WAIT aborts the store.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_re = 1'b0;
        req_addr = 32'h20; req_func3 = 3'd2; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        #1 check_eq("stall_pre_abort", stall, 1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_rsp", rsp_valid, 0);
        check_eq("abort_stall", stall, 0);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("no_rsp_after_abort", rsp_valid, 0);
        end
        check_eq("ready_after_abort", req_ready, 1);
        do_req(1'b1, 1'b0, 32'h20, 3'd2, 32'd0, rd, er);

        for (int n = 0; n < 150; n++) begin
            int kind;
            logic lre, lwe;
            kind = $urandom_range(0, 9);
            lre = (kind < 5) || (kind == 9);
            lwe = (kind >= 5);
            a = $urandom;
            a[10:6] = 5'd0;
            do_req(lre, lwe, a, 3'($urandom_range(0, 7)), $urandom, rd, er);
        end

        // Zero wait states, requests held valid back to back.
        @(posedge clk); #1;
        z_valid = 1'b1; z_we = 1'b1; z_re = 1'b0;
        z_addr = 32'h4; z_func3 = 3'd2; z_wdata = 32'hA5A50F0F;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                check_eq("z_stall_idle", z_stall, 1);
                check_eq("z_ready_idle", z_ready, 1);
                check_eq("z_rvalid_idle", z_rvalid, 0);
            end else begin
                check_eq("z_rvalid", z_rvalid, 1);
                check_eq("z_stall_resp", z_stall, 0);
                check_eq("z_ready_resp", z_ready, 0);
                check_eq("z_err", z_err, 0);
                check_eq("z_rdata", z_rdata, (i == 1) ? 32'h0 : 32'hA5A50F0F);
            end
            if (i == 1) begin
                z_we = 1'b0; z_re = 1'b1;
            end
            @(posedge clk); #2;
        end
        z_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 512, meaning the number of 32-bit memory words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states between request accept and response (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the MEM-stage request is present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_re, input, 1, meaning the request is a load (MemRead).
REQ-008 The block SHALL have port req_we, input, 1, meaning the request is a store (MemWrite).
REQ-009 The block SHALL have port req_addr, input, 32, meaning the byte address (Alu_Result).
REQ-010 The block SHALL have port req_func3, input, 3, meaning the access size and sign (func3).
REQ-011 The block SHALL have port req_wdata, input, 32, meaning the store data (RD_Two).
REQ-012 The block SHALL have port rsp_valid, output, 1, meaning a one-cycle response pulse.
REQ-013 The block SHALL have port rsp_rdata, output, 32, meaning the extended load data (MemReadData).
REQ-014 The block SHALL have port rsp_err, output, 1, meaning the access was rejected; qualified by rsp_valid.
REQ-015 The block SHALL have port stall, output, 1, meaning the pipeline is held while an access is outstanding.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted when req_valid=1, req_ready=1 and (req_re or req_we)=1; accept latches addr, func3, wdata, re and we.
REQ-018 On accept, the FSM SHALL go to WAIT when WAIT_CYCLES>0, loading a counter with WAIT_CYCLES-1; with WAIT_CYCLES=0 it SHALL go directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP. Accept-to-rsp_valid latency is therefore WAIT_CYCLES+1 cycles.
REQ-020 In RESP, rsp_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE; IDLE SHALL NOT accept in that same RESP cycle.
REQ-021 req_valid with re=we=0 SHALL be ignored and SHALL leave the FSM in IDLE.
REQ-022 stall SHALL equal (IDLE and req_valid and (re or we)) or WAIT; stall SHALL be 0 in RESP.
REQ-023 Word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-024 Stores SHALL use func3 000=SB (byte lane addr[1:0]), 001=SH (lane addr[1]), 010=SW; only the addressed byte lanes SHALL be written, in the RESP cycle.
REQ-025 Loads SHALL use func3 000=LB sign-extended, 001=LH sign-extended, 010=LW, 100=LBU zero-extended, 101=LHU zero-extended, taken from the addressed lane(s).
REQ-026 The following SHALL set rsp_err=1, perform no memory write and return rsp_rdata=0: half access with addr[0]=1, word access with addr[1:0]!=0, an undefined func3, or re=we=1.
REQ-027 rsp_rdata SHALL be 0 whenever rsp_valid=0 or the request was a store.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and stall=0; req_ready SHALL be 1 once reset_n=1.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A reset asserted while in WAIT SHALL abort the access with no memory write and no response.

Verification
REQ-031 SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> rsp_valid pulses 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-032 SB addr 0x13 data 0x80, then LB 0x13 -> rdata 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-033 LH addr 0x11 -> rsp_err=1, rdata 0; SW addr 0x12 -> rsp_err=1, and a following LW 0x10 shows the word unchanged.
REQ-034 SW addr 0x800 (DEPTH_WORDS=512) data 0x1234 -> LW addr 0x0 returns 0x00001234 (wrap).
REQ-035 SW accepted, reset_n pulsed low during WAIT -> no rsp_valid, req_ready=1 after release, and a following LW shows the old data.
REQ-036 WAIT_CYCLES=0 with back-to-back LW requests held valid -> accepts every 2 cycles, rsp_valid 1 cycle after each accept, stall low only in RESP cycles.
